button_event_decoder: RTL and testbench

Classifies the clean level from the button debouncer into single-cycle press events: short press, long press, and double press. It sits directly downstream of the debouncer in the 100 MHz `clk` domain and feeds the control logic, which reacts only to these event pulses and never to raw levels. One press gesture produces exactly one event pulse.

---
 rtl/button_event_decoder_if.sv | 25 ++
 rtl/button_event_decoder.sv | 94 +++++++++
 tb/tb_button_event_decoder.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/button_event_decoder_if.sv
// Button level in, single-cycle gesture events and busy flag out.
// The decoder drives the master side; the control logic takes the slave side.
interface button_event_decoder_if;
  logic btn_level;
  logic short_press;
  logic long_press;
  logic double_press;
  logic busy;

  modport master (
    input  btn_level,
    output short_press,
    output long_press,
    output double_press,
    output busy
  );

  modport slave (
    output btn_level,
    input  short_press,
    input  long_press,
    input  double_press,
    input  busy
  );
endinterface

// File: rtl/button_event_decoder.sv
// Turns a debounced button level into short/long/double press pulses, one per gesture.
// Pulses are registered one cycle after the deciding sample; the input is never stalled.
module button_event_decoder #(
  parameter int LONG_CYCLES = 100_000_000,
  parameter int GAP_CYCLES  = 30_000_000,
  parameter int CNT_W       = 27
) (
  input  logic                   clk,
  input  logic                   rst_n,
  button_event_decoder_if.master bus
);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESSED      = 2'd1,
    WAIT_SECOND  = 2'd2,
    WAIT_RELEASE = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             btn_prev;
  logic             rise;

  // btn_prev resets high so a button held through reset is not seen as a new press.
  assign rise = bus.btn_level & ~btn_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      cnt              <= '0;
      btn_prev         <= 1'b1;
      bus.short_press  <= 1'b0;
      bus.long_press   <= 1'b0;
      bus.double_press <= 1'b0;
      bus.busy         <= 1'b0;
    end else begin
      btn_prev         <= bus.btn_level;
      bus.short_press  <= 1'b0;
      bus.long_press   <= 1'b0;
      bus.double_press <= 1'b0;
      case (state)
        IDLE: begin
          if (rise) begin
            state    <= PRESSED;
            cnt      <= CNT_ONE;
            bus.busy <= 1'b1;
          end
        end
        PRESSED: begin
          if (bus.btn_level) begin
            if (cnt == LONG_LAST) begin
              bus.long_press <= 1'b1;
              state          <= WAIT_RELEASE;
            end else begin
              cnt <= cnt + CNT_ONE;
            end
          end else begin
            state <= WAIT_SECOND;
            cnt   <= CNT_ONE;
          end
        end
        WAIT_SECOND: begin
          // A press on the timeout edge wins over the timeout.
          if (bus.btn_level) begin
            bus.double_press <= 1'b1;
            state            <= WAIT_RELEASE;
          end else if (cnt == GAP_LAST) begin
            bus.short_press <= 1'b1;
            state           <= IDLE;
            bus.busy        <= 1'b0;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        WAIT_RELEASE: begin
          if (!bus.btn_level) begin
            state    <= IDLE;
            bus.busy <= 1'b0;
          end
        end
        default: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_button_event_decoder.sv
// Directed gesture scenarios plus random level sequences, checked cycle by cycle against a timestamp model.
module tb_button_event_decoder;
  localparam int LONG = 8;
  localparam int GAP  = 5;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  button_event_decoder_if bus ();

  button_event_decoder #(
    .LONG_CYCLES(LONG),
    .GAP_CYCLES (GAP),
    .CNT_W      (4)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: gesture described by the edge index of its first high sample and of its release.
  int edge_n;
  int g_start;
  int rel_at;
  bit held_done;
  bit m_prev;
  bit e_short, e_long, e_double;
  int n_short, n_long, n_double;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, edge_n);
    end
  endtask

  task automatic model_reset();
    g_start   = -1;
    rel_at    = -1;
    held_done = 1'b0;
    m_prev    = 1'b1;
    e_short   = 1'b0;
    e_long    = 1'b0;
    e_double  = 1'b0;
  endtask

  task automatic model_step(input bit lvl);
    e_short  = 1'b0;
    e_long   = 1'b0;
    e_double = 1'b0;
    if (g_start < 0) begin
      if (lvl && !m_prev) g_start = edge_n;
    end else if (held_done) begin
      if (!lvl) begin
        g_start   = -1;
        held_done = 1'b0;
      end
    end else if (rel_at < 0) begin
      if (!lvl) rel_at = edge_n;
      else if (edge_n - g_start == LONG - 1) begin
        e_long    = 1'b1;
        held_done = 1'b1;
      end
    end else begin
      if (lvl) begin
        e_double  = 1'b1;
        held_done = 1'b1;
        rel_at    = -1;
      end else if (edge_n - rel_at == GAP - 1) begin
        e_short = 1'b1;
        g_start = -1;
        rel_at  = -1;
      end
    end
    m_prev = lvl;
    edge_n++;
  endtask

  task automatic cycle(input bit lvl);
    logic [3:0] outs;
    @(negedge clk);
    bus.btn_level = lvl;
    @(posedge clk);
    model_step(lvl);
    #1;
    outs = {bus.busy, bus.double_press, bus.long_press, bus.short_press};
    chk("outs", 32'(outs), 32'({g_start >= 0, e_double, e_long, e_short}));
    chk("onehot", 32'($onehot0(outs[2:0])), 32'd1);
    n_short  += int'(bus.short_press);
    n_long   += int'(bus.long_press);
    n_double += int'(bus.double_press);
  endtask

  task automatic run(input bit lvl, input int n);
    for (int i = 0; i < n; i++) cycle(lvl);
  endtask

  task automatic clear_counts();
    n_short  = 0;
    n_long   = 0;
    n_double = 0;
  endtask

  task automatic expect_counts(input string tag, input int s, input int l, input int d);
    chk({tag, "_short"}, 32'(n_short), 32'(s));
    chk({tag, "_long"}, 32'(n_long), 32'(l));
    chk({tag, "_double"}, 32'(n_double), 32'(d));
    clear_counts();
  endtask

  task automatic do_reset(input bit lvl);
    @(negedge clk);
    bus.btn_level = lvl;
    rst_n = 1'b0;
    #1;
    chk("rst_async", 32'({bus.busy, bus.double_press, bus.long_press, bus.short_press}), 32'd0);
    model_reset();
    repeat (2) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  initial begin
    edge_n = 0;
    model_reset();
    clear_counts();
    rst_n = 1'b0;
    bus.btn_level = 1'b0;
    #1;
    chk("reset_state", 32'({bus.busy, bus.double_press, bus.long_press, bus.short_press}), 32'd0);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b1;
    run(0, 3);

    // Short press: 3 high, release, pulse GAP samples later.
    run(1, 3); run(0, 10);
    expect_counts("short", 1, 0, 0);

    // Long press held 20 cycles, then just-under-long press of 7.
    run(1, 20); run(0, 10);
    expect_counts("long20", 0, 1, 0);
    run(1, 7); run(0, 10);
    expect_counts("long7", 1, 0, 0);

    // Double press with a held second press.
    run(1, 2); run(0, 3); run(1, 10); run(0, 10);
    expect_counts("double", 0, 0, 1);

    // Second rise on the timeout edge, then one sample later.
    run(1, 2); run(0, 4); run(1, 3); run(0, 10);
    expect_counts("gap_edge", 0, 0, 1);
    run(1, 2); run(0, 5); run(1, 3); run(0, 10);
    expect_counts("gap_late", 2, 0, 0);

    // Button held through reset release, then a real press.
    do_reset(1);
    run(1, 12);
    expect_counts("held_rst", 0, 0, 0);
    run(0, 2); run(1, 3); run(0, 10);
    expect_counts("after_held", 1, 0, 0);

    // Reset in the middle of a press discards the gesture.
    run(1, 4);
    do_reset(0);
    run(0, 12);
    expect_counts("mid_rst", 0, 0, 0);

    for (int i = 0; i < 300; i++) begin
      run(i % 2 == 0, (i % 2 == 0) ? int'($urandom_range(1, 12)) : int'($urandom_range(1, 8)));
    end
    run(0, 12);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
